io_window_router: RTL
=====================

Name: io_window_router

Overview:
- Registered, parametrised successor to the fixed LED/SW/VGA address decode for the Raisin64 IO region.
- Accepts one master bus request at a time.
- Checks the address is canonical (bits 63:48 sign-extend bit 47) and lies in the IO half (bit 47 = 1).
- Decodes addr[47:WIN_LSB] against NUM_SLAVES programmable window bases, forwards the request to the matching peripheral, and returns its data.
- Returns a bus error on unmapped, non-IO or non-canonical addresses, or on peripheral timeout.

Parameters:
- NUM_SLAVES, 4, number of peripheral windows (1..16).
- DATA_W, 64, data width.
- WIN_LSB, 14, lowest address bit of the window index; window size is 2^WIN_LSB bytes.
- BASES, {34'h2_0000_0004, 34'h2_0000_0003, 34'h2_0000_0002, 34'h2_0000_0001}, flattened array of (48-WIN_LSB)-bit window indices; slave i uses slice i.
- TIMEOUT, 255, maximum cycles to wait for s_ack before error (1..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- m_req  in  1  master request, held until m_ack
- m_we  in  1  1 = write
- m_addr  in  64  byte address
- m_wdata  in  DATA_W  write data
- m_ack  out  1  one-cycle completion pulse
- m_err  out  1  valid with m_ack; 1 = bus error
- m_rdata  out  DATA_W  read data, valid with m_ack
- s_req  out  NUM_SLAVES  one-hot peripheral request
- s_we  out  1  registered copy of m_we
- s_addr  out  WIN_LSB  offset within window
- s_wdata  out  DATA_W  registered write data
- s_ack  in  NUM_SLAVES  per-peripheral completion
- s_rdata  in  NUM_SLAVES*DATA_W  flattened per-peripheral read data
- busy  out  1  state != IDLE

Behaviour:
- Reset: the design uses one clock, clk; reset is asynchronous and active-low on rst_n. All outputs reset to 0 and state to IDLE; the timeout counter and latched fields clear.
- FSM states: IDLE, DECODE, ACCESS, RESP.
- IDLE:
  - m_req=1 latches m_we, m_addr, m_wdata into internal registers, then goes to DECODE.
  - m_req is sampled only in IDLE.
- DECODE (1 cycle):
  - Computes canon = (addr[63:48] == {16{addr[47]}}), io = addr[47], and hit[i] = (addr[47:WIN_LSB] == BASES[i]).
  - If canon & io & |hit: sel = lowest-index hit, so overlapping windows resolve to the lower index. Drive s_req[sel]=1, load s_addr, s_we and s_wdata, clear the counter, go to ACCESS.
  - Otherwise go to RESP with err=1 and rdata=0.
- ACCESS:
  - s_req[sel] is held.
  - If s_ack[sel]=1: capture s_rdata slice sel, deassert s_req next cycle, go to RESP with err=0.
  - Else if the counter equals TIMEOUT-1: deassert s_req, go to RESP with err=1 and rdata=0.
  - Otherwise increment the counter.
  - s_ack from non-selected slaves is ignored.
- RESP (1 cycle): m_ack=1, m_err=err, m_rdata=captured data, then IDLE.
- m_rdata holds until the next RESP. m_err is 0 outside RESP.
- Latency:
  - Error decode: m_ack 2 cycles after the acceptance edge.
  - Mapped access with s_ack in its first ACCESS cycle: m_ack 3 cycles after acceptance.
  - Minimum back-to-back period: 4 cycles.
- Write data is never forwarded on error paths; s_req stays 0.
- Reset mid-ACCESS: s_req drops immediately (async) and no m_ack is produced. The peripheral must tolerate an abandoned request.
- A late s_ack arriving after timeout, while in RESP or IDLE, is ignored.

Decomposition:
- Shared package raisin64_map_pkg holds:
  - the IO window index constants (LED=34'h2_0000_0001, SW=..002, VGA=..003), reused by the top-level BASES;
  - the state encoding;
  - WIN_LSB default.
- One natural sub-module: io_window_decode, purely combinational. It takes addr and BASES and outputs hit_onehot, canon and io, with lowest-index priority. This lets the decode be tested exhaustively on its own.

Test Plan:
- Read slave 1:
  - Stimulus: m_addr=64'hFFFF_8000_0000_8010, m_we=0; s_ack[1] asserted the first cycle s_req[1]=1 with s_rdata[1]=64'hDEAD_BEEF.
  - Required: s_addr=14'h0010; m_ack 3 cycles after acceptance; m_err=0; m_rdata=64'hDEAD_BEEF.
- Write slave 3:
  - Stimulus: m_addr=64'hFFFF_8000_0001_0004, m_wdata=5, ack after 10 cycles.
  - Required: s_we=1, s_wdata=5, s_addr=4; s_req[3] high for exactly 11 cycles; m_err=0.
- Unmapped, non-IO and non-canonical addresses:
  - Stimulus: 64'hFFFF_8000_0002_0000, then 64'h0000_0000_0000_1000, then 64'h0001_8000_0000_4000.
  - Required: each gives m_ack with m_err=1 at 2 cycles; s_req remains 0.
- Timeout:
  - Stimulus: TIMEOUT=8; slave 0 never acks.
  - Required: s_req[0] high 8 cycles; m_ack with m_err=1 and m_rdata=0. A s_ack[0] injected 2 cycles later produces no second m_ack.
- Overlap and wrong-slave ack:
  - Stimulus: BASES with slices 0 and 2 equal; s_ack[2] pulsed during the access.
  - Required: only s_req[0] asserted; s_ack[2] is ignored; completion occurs only on s_ack[0].
- Reset mid-access:
  - Stimulus: rst_n low during ACCESS.
  - Required: s_req and busy go to 0 before the next clk edge; no m_ack; the next request after reset completes normally.

Source files
------------

// File: rtl/raisin64_map_pkg.sv
// Shared definitions for the Raisin64 IO region map.
// Holds the window indices of the fixed peripherals (addr[47:WIN_LSB]),
// the default window granularity and the router state encoding.
package raisin64_map_pkg;

    // Default window granularity: 16 KiB windows.
    localparam int RAISIN_WIN_LSB = 14;
    localparam int RAISIN_IDX_W   = 48 - RAISIN_WIN_LSB;

    // Window indices of the IO peripherals (bit 33 set = upper/IO half).
    localparam logic [RAISIN_IDX_W-1:0] IO_IDX_LED = 34'h2_0000_0001;
    localparam logic [RAISIN_IDX_W-1:0] IO_IDX_SW  = 34'h2_0000_0002;
    localparam logic [RAISIN_IDX_W-1:0] IO_IDX_VGA = 34'h2_0000_0003;
    localparam logic [RAISIN_IDX_W-1:0] IO_IDX_EXT = 34'h2_0000_0004;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } router_state_t;

endpackage

// File: rtl/io_window_router_if.sv
// Master-side request/response bus of the IO window router.
// master modport: the bus initiator (CPU side).
// slave  modport: the router, which consumes requests and returns completions.
interface io_window_router_if #(
    parameter int DATA_W = 64
);
    logic              m_req;
    logic              m_we;
    logic [63:0]       m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic              m_err;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_err, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_ack, m_err, m_rdata
    );
endinterface

// File: rtl/io_window_decode.sv
// Purely combinational IO window decoder.
// Ports:
//   addr       in  64          byte address
//   hit_onehot out NUM_SLAVES  matching window, lowest index wins on overlap
//   canon      out 1           addr[63:48] sign-extends addr[47]
//   io         out 1           address lies in the IO (upper) half
module io_window_decode
    import raisin64_map_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int WIN_LSB    = RAISIN_WIN_LSB,
    parameter logic [NUM_SLAVES*(48-WIN_LSB)-1:0] BASES = '0
) (
    input  logic [63:0]           addr,
    output logic [NUM_SLAVES-1:0] hit_onehot,
    output logic                  canon,
    output logic                  io
);
    localparam int IDX_W = 48 - WIN_LSB;

    logic [NUM_SLAVES-1:0] raw_hit;
    logic [NUM_SLAVES-1:0] lower_hit;   // any lower-index window also hit

    assign canon = (addr[63:48] == {16{addr[47]}});
    assign io    = addr[47];

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cmp
            assign raw_hit[gi] = (addr[47:WIN_LSB] == BASES[gi*IDX_W +: IDX_W]);
        end
    endgenerate

    assign lower_hit[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_SLAVES; gi++) begin : g_prio
            assign lower_hit[gi] = lower_hit[gi-1] | raw_hit[gi-1];
        end
    endgenerate

    assign hit_onehot = raw_hit & ~lower_hit;

endmodule

// File: rtl/io_window_router.sv
// Registered IO window router for the Raisin64 IO region.
// Accepts one master request at a time, validates and decodes the address
// against NUM_SLAVES window bases, forwards to the selected peripheral and
// returns its data, or a bus error (bad address / peripheral timeout).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         master request/response bus (slave modport)
//   s_req       one-hot peripheral request
//   s_we/s_addr/s_wdata  registered request fields (s_addr = offset in window)
//   s_ack       per-peripheral completion, s_rdata flattened read data
//   busy        router is not idle
module io_window_router
    import raisin64_map_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 64,
    parameter int WIN_LSB    = RAISIN_WIN_LSB,
    parameter logic [NUM_SLAVES*(48-WIN_LSB)-1:0] BASES =
        {IO_IDX_EXT, IO_IDX_VGA, IO_IDX_SW, IO_IDX_LED},
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    io_window_router_if.slave            bus,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_we,
    output logic [WIN_LSB-1:0]           s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic                         busy
);
    // Last ACCESS cycle index before giving up on the peripheral.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    router_state_t state_reg, state_next;

    logic                  we_reg;
    logic [63:0]           addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [NUM_SLAVES-1:0] s_req_reg;
    logic                  s_we_reg;
    logic [WIN_LSB-1:0]    s_addr_reg;
    logic [DATA_W-1:0]     s_wdata_reg;
    logic [15:0]           cnt_reg;
    logic                  err_reg;
    logic [DATA_W-1:0]     rdata_reg;

    logic [NUM_SLAVES-1:0] hit_onehot;
    logic                  canon;
    logic                  io;
    logic                  decode_ok;
    logic                  ack_sel;
    logic [DATA_W-1:0]     sel_rdata;

    io_window_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .WIN_LSB    (WIN_LSB),
        .BASES      (BASES)
    ) u_decode (
        .addr       (addr_reg),
        .hit_onehot (hit_onehot),
        .canon      (canon),
        .io         (io)
    );

    assign decode_ok = canon & io & (|hit_onehot);

    // s_req_reg doubles as the selection: acks from other slaves are masked.
    assign ack_sel = |(s_ack & s_req_reg);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_req_reg[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.m_req) state_next = DECODE;
            DECODE:  state_next = decode_ok ? ACCESS : RESP;
            ACCESS:  if (ack_sel || (cnt_reg == TO_LAST)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            s_req_reg   <= '0;
            s_we_reg    <= 1'b0;
            s_addr_reg  <= '0;
            s_wdata_reg <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.m_req) begin
                        we_reg    <= bus.m_we;
                        addr_reg  <= bus.m_addr;
                        wdata_reg <= bus.m_wdata;
                    end
                end
                DECODE: begin
                    if (decode_ok) begin
                        s_req_reg   <= hit_onehot;
                        s_addr_reg  <= addr_reg[WIN_LSB-1:0];
                        s_we_reg    <= we_reg;
                        s_wdata_reg <= wdata_reg;
                        cnt_reg     <= '0;
                    end else begin
                        // Request fields are not forwarded on error paths.
                        err_reg   <= 1'b1;
                        rdata_reg <= '0;
                    end
                end
                ACCESS: begin
                    if (ack_sel) begin
                        rdata_reg <= sel_rdata;
                        err_reg   <= 1'b0;
                        s_req_reg <= '0;
                    end else if (cnt_reg == TO_LAST) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                        s_req_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_req       = s_req_reg;
    assign s_we        = s_we_reg;
    assign s_addr      = s_addr_reg;
    assign s_wdata     = s_wdata_reg;
    assign busy        = (state_reg != IDLE);
    assign bus.m_ack   = (state_reg == RESP);
    assign bus.m_err   = (state_reg == RESP) & err_reg;
    assign bus.m_rdata = rdata_reg;

endmodule
